stack_op_sequencer: RTL and testbench
=====================================

# stack_op_sequencer

Control-side initiator for the register-stack / ALU / write-mux datapath. It accepts 16-bit stack instructions over a valid/ready handshake and decodes each one into a timed sequence of `stackOP`, `aluOP`, `mux_selector` and `immediate` drives. It sits between instruction fetch and the stack datapath, and owns all sequencing the datapath cannot do itself: ALU settle cycles, depth checking and overflow capture.

## Interface
Parameters:
- `DEPTH`, 8: stack capacity in entries; sets the depth-counter width to clog2(DEPTH+1).

Ports:
- `CLK`, in, 1: the single clock; rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `instr_valid`, in, 1: `instr` and `instr_imm` are valid.
- `instr_ready`, out, 1: sequencer can accept an instruction.
- `instr`, in, 16: instruction word.
- `instr_imm`, in, 16: immediate for PUSHI; ignored by other classes.
- `ovf_clear`, in, 1: clears the sticky `ovf_flag`.
- `stackOP`, out, 3: stack operation.
- `aluOP`, out, 4: ALU operation select.
- `mux_selector`, out, 1: write-mux select. 0 selects the ALU result, 1 selects the immediate.
- `immediate`, out, 16: latched immediate driven to the write mux.
- `Overflow`, in, 1: ALU overflow, sampled in WB.
- `done`, out, 1: one-cycle pulse marking the final cycle of an instruction.
- `err`, out, 1: one-cycle pulse marking a rejected instruction.
- `ovf_flag`, out, 1: sticky ALU overflow.
- `depth`, out, clog2(DEPTH+1): current number of stack entries.

## Operation
- stackOP encoding:
  - 000 HOLD
  - 001 PUSH (w to top)
  - 010 POP
  - 011 REPL (w replaces top)
  - 100 POPREPL (pop, then w replaces the new top)
- Instruction class is `instr[15:14]`:
  - 00 NOP
  - 01 PUSHI
  - 10 POP
  - 11 ALU: `instr[3:0]` is the aluOP; `instr[4]` = 1 selects unary (REPL), 0 selects binary (POPREPL).
- `instr[13:5]` is ignored.
- FSM states: IDLE, EXEC, SETTLE, WB.
- IDLE:
  - `instr_ready` = 1.
  - On `instr_valid`, the sequencer latches `instr` and `instr_imm`.
  - ALU class goes to SETTLE; every other class goes to EXEC.
- EXEC (1 cycle):
  - PUSHI drives PUSH with `mux_selector` = 1 and `immediate` = latched imm.
  - POP drives POP.
  - NOP drives HOLD.
  - `done` = 1, then the FSM returns to IDLE.
- SETTLE (1 cycle):
  - `aluOP` is driven and `stackOP` = HOLD, giving the ALU a full cycle to settle.
- WB (1 cycle):
  - `aluOP` is held and `mux_selector` = 0.
  - `stackOP` is REPL for unary or POPREPL for binary.
  - `Overflow` is sampled: if it is 1, `ovf_flag` sets.
  - `done` = 1, then the FSM returns to IDLE.
- `aluOP` holds its last value outside SETTLE and WB. `immediate` holds its last latched value.
- Depth rules:
  - PUSH adds 1, POP subtracts 1, POPREPL subtracts 1, REPL and HOLD leave depth unchanged.
  - Depth updates on the edge that ends the issuing cycle.
- `ovf_flag` priority: a set in WB wins over `ovf_clear` in the same cycle.

## Timing
- Reset values: FSM in IDLE; `stackOP` = HOLD; `aluOP` = 0; `mux_selector` = 0; `immediate` = 0; `done`, `err`, `ovf_flag` = 0; `depth` = 0. `instr_ready` = 0 while `reset` is high.
- An asserted `reset` mid-sequence forces IDLE and HOLD immediately, with no edge needed. A partially issued instruction is dropped.
- Handshake: transfer happens on a rising edge with `instr_valid` & `instr_ready`. `instr_ready` is 0 in every non-IDLE state, so there is no back-to-back acceptance.
- Latency, with acceptance at edge N:
  - Non-ALU: EXEC is cycle N..N+1; the stack updates at edge N+1; `instr_ready` is high again after edge N+1. Throughput is 1 instruction per 2 cycles.
  - ALU: SETTLE is N..N+1, WB is N+1..N+2; the stack updates at edge N+2. Throughput is 1 instruction per 3 cycles.

## Configuration
- `SEQ_DEPTH_CHECK_EN` defined:
  - The `depth` counter is live.
  - Violations are PUSH with `depth` = DEPTH, POP or unary with `depth` = 0, and binary with `depth` < 2.
  - A violating instruction still occupies its EXEC or WB slot. In that slot `stackOP` = HOLD, `err` = 1, `done` = 0, `ovf_flag` is not sampled, and `depth` is unchanged.
- `SEQ_DEPTH_CHECK_EN` undefined:
  - No checks are performed; `err` is tied to 0 and `depth` is tied to 0.
  - Every instruction issues as decoded.

## Structure
- Package `stack_seq_pkg` holds:
  - the stackOP codes as localparams,
  - the instruction class codes,
  - the FSM state enum,
  - the bit positions of the class, unary and aluOP fields.
- One sub-module, `seq_depth_tracker`, instantiated only under `SEQ_DEPTH_CHECK_EN`:
  - inputs: the pending stackOP;
  - outputs: `depth` and a violation flag;
  - the counter saturates at 0 and DEPTH.

## Test plan
- PUSHI with imm 0x1234 after reset: EXEC cycle shows PUSH, `mux_selector` = 1, `immediate` = 0x1234, `done` = 1, `depth` 0 to 1; `instr_ready` returns high 2 cycles after acceptance.
- PUSHI 5, PUSHI 3, then binary ALU with aluOP 0x1: SETTLE shows HOLD with aluOP 0x1; WB shows POPREPL with `mux_selector` = 0; `depth` goes 2 to 1; `done` pulses 3 cycles after acceptance.
- Unary ALU with `Overflow` = 1 in WB: `stackOP` = REPL and `ovf_flag` sets. Next, `ovf_clear` clears it; then `ovf_clear` asserted in the same cycle as a WB with `Overflow` = 1 leaves `ovf_flag` = 1.
- With `SEQ_DEPTH_CHECK_EN`: POP at depth 0 gives `err` = 1, `stackOP` = HOLD, depth stays 0. DEPTH+1 PUSHIs: the last one gives `err` = 1 and depth stays 8.
- `reset` asserted during SETTLE: outputs go to HOLD and reset values asynchronously, and the FSM is in IDLE after deassertion.
- `instr_valid` held high for 5 consecutive cycles across 2 instructions: exactly 2 transfers, one per IDLE cycle; `instr` changes while `instr_ready` = 0 are ignored.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg
//   Shared encodings for the stack-op sequencer: stackOP codes, instruction
//   class codes, instruction field positions and the sequencer FSM states.
//   Optional feature macro used by the importers: SEQ_DEPTH_CHECK_EN.
package stack_seq_pkg;

   // stackOP codes driven to the register stack
   localparam logic [2:0] OP_HOLD    = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_REPL    = 3'b011;
   localparam logic [2:0] OP_POPREPL = 3'b100;

   // instruction classes, instr[CLS_HI:CLS_LO]
   localparam logic [1:0] CLS_NOP   = 2'b00;
   localparam logic [1:0] CLS_PUSHI = 2'b01;
   localparam logic [1:0] CLS_POP   = 2'b10;
   localparam logic [1:0] CLS_ALU   = 2'b11;

   // instruction field positions
   localparam int CLS_HI    = 15;
   localparam int CLS_LO    = 14;
   localparam int UNARY_BIT = 4;
   localparam int ALU_HI    = 3;
   localparam int ALU_LO    = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_SETTLE,
      S_WB
   } seq_state_t;

   // stackOP issued in the EXEC slot for a non-ALU class
   function automatic logic [2:0] exec_op(input logic [1:0] cls);
      logic [2:0] op;
      case (cls)
         CLS_PUSHI: op = OP_PUSH;
         CLS_POP:   op = OP_POP;
         default:   op = OP_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/seq_depth_tracker.sv
// seq_depth_tracker
//   Tracks the number of live stack entries and flags an operation that
//   would underflow or overflow the stack.
//   Ports:
//     clk, rst  - clock, asynchronous active-high reset
//     check_op  - stackOP about to be issued (checked, not counted)
//     apply_op  - stackOP currently driven to the stack (counted at edge)
//     depth     - current entry count, saturates at 0 and DEPTH
//     viol      - check_op is illegal at the current depth
module seq_depth_tracker
   import stack_seq_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    check_op,
   input  logic [2:0]    apply_op,
   output logic [DW-1:0] depth,
   output logic          viol
);

   localparam logic [DW-1:0] FULL = DW'(DEPTH);

   always_comb begin
      viol = 1'b0;
      case (check_op)
         OP_PUSH:         viol = (depth == FULL);
         OP_POP, OP_REPL: viol = (depth == '0);
         OP_POPREPL:      viol = (depth < DW'(2));
         default:         viol = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
      end else begin
         case (apply_op)
            OP_PUSH:            if (depth != FULL) depth <= depth + 1'b1;
            OP_POP, OP_POPREPL: if (depth != '0)   depth <= depth - 1'b1;
            default:            ;
         endcase
      end
   end

endmodule

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer
//   Accepts 16-bit stack instructions over valid/ready and sequences the
//   stack / ALU / write-mux datapath: one EXEC cycle for NOP/PUSHI/POP,
//   SETTLE + WB cycles for ALU instructions. All datapath drives are
//   registered.
//   Ports:
//     CLK, reset             - clock, asynchronous active-high reset
//     instr_valid/ready      - instruction handshake (ready only in IDLE)
//     instr, instr_imm       - instruction word and PUSHI immediate
//     ovf_clear              - clears ovf_flag (a WB set wins)
//     stackOP, aluOP         - stack operation, ALU operation select
//     mux_selector           - 0 = ALU result, 1 = immediate
//     immediate              - latched immediate
//     Overflow               - ALU overflow, sampled in WB
//     done, err              - one-cycle completion / rejection pulses
//     ovf_flag               - sticky ALU overflow
//     depth                  - stack entry count
//   Macro SEQ_DEPTH_CHECK_EN enables depth tracking and rejection of
//   instructions that would over/underflow the stack; otherwise err and
//   depth are tied to 0.
module stack_op_sequencer
   import stack_seq_pkg::*;
#(
   parameter int  DEPTH = 8,
   localparam int DW    = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [15:0]   instr,
   input  logic [15:0]   instr_imm,
   input  logic          ovf_clear,
   output logic [2:0]    stackOP,
   output logic [3:0]    aluOP,
   output logic          mux_selector,
   output logic [15:0]   immediate,
   input  logic          Overflow,
   output logic          done,
   output logic          err,
   output logic          ovf_flag,
   output logic [DW-1:0] depth
);

   seq_state_t state;
   logic       unary_q;
   logic       err_q;
   logic       viol;
   logic [1:0] cls;

   // instr[13:5] carries no meaning for this block
   logic       unused_instr_bits;
   assign unused_instr_bits = ^instr[13:5];

   assign cls         = instr[CLS_HI:CLS_LO];
   assign instr_ready = (state == S_IDLE) && !reset;
   assign err         = err_q;

`ifdef SEQ_DEPTH_CHECK_EN
   // Operation that the next slot would issue; checked one edge ahead so
   // the slot itself can already drive HOLD/err.
   logic [2:0] cand_op;

   always_comb begin
      cand_op = OP_HOLD;
      case (state)
         S_IDLE:   cand_op = exec_op(cls);
         S_SETTLE: cand_op = unary_q ? OP_REPL : OP_POPREPL;
         default:  cand_op = OP_HOLD;
      endcase
   end

   seq_depth_tracker #(.DEPTH(DEPTH)) u_depth (
      .clk      (CLK),
      .rst      (reset),
      .check_op (cand_op),
      .apply_op (stackOP),
      .depth    (depth),
      .viol     (viol)
   );
`else
   assign depth = '0;
   assign viol  = 1'b0;
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         stackOP      <= OP_HOLD;
         aluOP        <= 4'h0;
         mux_selector <= 1'b0;
         immediate    <= 16'h0000;
         done         <= 1'b0;
         err_q        <= 1'b0;
         ovf_flag     <= 1'b0;
         unary_q      <= 1'b0;
      end else begin
         // pulses and slot drives default back to idle values
         done         <= 1'b0;
         err_q        <= 1'b0;
         stackOP      <= OP_HOLD;
         mux_selector <= 1'b0;
         if (ovf_clear) ovf_flag <= 1'b0;

         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  immediate <= instr_imm;
                  unary_q   <= instr[UNARY_BIT];
                  if (cls == CLS_ALU) begin
                     state <= S_SETTLE;
                     aluOP <= instr[ALU_HI:ALU_LO];
                  end else begin
                     state <= S_EXEC;
                     err_q <= viol;
                     done  <= !viol;
                     if (!viol) begin
                        stackOP      <= exec_op(cls);
                        mux_selector <= (cls == CLS_PUSHI);
                     end
                  end
               end
            end
            S_EXEC: state <= S_IDLE;
            S_SETTLE: begin
               state <= S_WB;
               err_q <= viol;
               done  <= !viol;
               if (!viol) stackOP <= unary_q ? OP_REPL : OP_POPREPL;
            end
            S_WB: begin
               state <= S_IDLE;
               // set after the clear above so a WB overflow wins
               if (Overflow && !err_q) ovf_flag <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer
//   Directed bench for stack_op_sequencer. Expected slot values are pushed
//   to a scoreboard queue when an instruction is driven and popped when the
//   DUT signals the end of that instruction. Adapts to SEQ_DEPTH_CHECK_EN.
module tb_stack_op_sequencer;
  import stack_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);
`ifdef SEQ_DEPTH_CHECK_EN
  localparam bit CHKEN = 1'b1;
`else
  localparam bit CHKEN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [15:0]   instr;
  logic [15:0]   instr_imm;
  logic          ovf_clear;
  logic [2:0]    stackOP;
  logic [3:0]    aluOP;
  logic          mux_selector;
  logic [15:0]   immediate;
  logic          Overflow;
  logic          done;
  logic          err;
  logic          ovf_flag;
  logic [DW-1:0] depth;

  typedef struct {
    logic [2:0]    op;
    logic          mux;
    logic [15:0]   imm;
    logic [3:0]    alu;
    logic          done;
    logic          err;
    logic [DW-1:0] dep_pre;
    logic [DW-1:0] dep_post;
    logic          flag_post;
  } exp_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  int         mdepth   = 0;
  logic       mflag    = 1'b0;
  logic [3:0] last_alu = 4'h0;

  stack_op_sequencer #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_imm    (instr_imm),
    .ovf_clear    (ovf_clear),
    .stackOP      (stackOP),
    .aluOP        (aluOP),
    .mux_selector (mux_selector),
    .immediate    (immediate),
    .Overflow     (Overflow),
    .done         (done),
    .err          (err),
    .ovf_flag     (ovf_flag),
    .depth        (depth)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [DW-1:0] exp_depth(input int d);
    return CHKEN ? DW'(d) : '0;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input logic [15:0] ins, input logic [15:0] imm,
                     input logic ovf, input logic clr);
    exp_t       e;
    exp_t       g;
    logic [2:0] op;
    bit         viol;
    bit         is_alu;
    int         k;
    is_alu = (ins[15:14] == 2'b11);
    case (ins[15:14])
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = ins[4] ? OP_REPL : OP_POPREPL;
      default: op = OP_HOLD;
    endcase
    viol = CHKEN && ((op == OP_PUSH && mdepth == DEPTH) ||
                     ((op == OP_POP || op == OP_REPL) && mdepth == 0) ||
                     (op == OP_POPREPL && mdepth < 2));
    if (is_alu) last_alu = ins[3:0];
    e.op      = viol ? OP_HOLD : op;
    e.mux     = (ins[15:14] == 2'b01) && !viol;
    e.imm     = imm;
    e.alu     = last_alu;
    e.done    = !viol;
    e.err     = viol;
    e.dep_pre = exp_depth(mdepth);
    if (!viol) begin
      if (op == OP_PUSH) mdepth++;
      else if ((op == OP_POP || op == OP_POPREPL) && mdepth > 0) mdepth--;
    end
    e.dep_post = exp_depth(mdepth);
    if (clr) mflag = 1'b0;
    if (is_alu && !viol && ovf) mflag = 1'b1;
    e.flag_post = mflag;

    k = 0;
    while (!instr_ready && k < 4) begin step(); k++; end
    chk("ready_pre", instr_ready === 1'b1);
    instr       = ins;
    instr_imm   = imm;
    Overflow    = ovf;
    ovf_clear   = clr;
    instr_valid = 1'b1;
    sbq.push_back(e);
    step();
    instr_valid = 1'b0;
    instr       = 16'h8000;
    instr_imm   = 16'hDEAD;
    if (is_alu) begin
      chk("settle_op", stackOP === OP_HOLD);
      chk("settle_alu", aluOP === ins[3:0]);
      chk("settle_done", done === 1'b0);
      chk("settle_ready", instr_ready === 1'b0);
      step();
    end
    k = 0;
    while (!(done || err) && k < 3) begin step(); k++; end
    g = sbq.pop_front();
    chk("slot_op", stackOP === g.op);
    chk("slot_mux", mux_selector === g.mux);
    chk("slot_imm", immediate === g.imm);
    chk("slot_alu", aluOP === g.alu);
    chk("slot_done", done === g.done);
    chk("slot_err", err === g.err);
    chk("slot_ready", instr_ready === 1'b0);
    chk("slot_depth", depth === g.dep_pre);
    step();
    Overflow  = 1'b0;
    ovf_clear = 1'b0;
    chk("post_depth", depth === g.dep_post);
    chk("post_done", done === 1'b0);
    chk("post_flag", ovf_flag === g.flag_post);
    chk("post_ready", instr_ready === 1'b1);
    chk("post_op", stackOP === OP_HOLD);
  endtask

  task automatic clear_flag();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    mflag = 1'b0;
    chk("ovf_cleared", ovf_flag === 1'b0);
  endtask

  initial begin
    int xfers;
    int dones;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    instr_imm   = 16'h0000;
    ovf_clear   = 1'b0;
    Overflow    = 1'b0;
    #2;
    chk("rst_ready", instr_ready === 1'b0);
    chk("rst_op", stackOP === OP_HOLD);
    chk("rst_alu", aluOP === 4'h0);
    chk("rst_mux", mux_selector === 1'b0);
    chk("rst_imm", immediate === 16'h0000);
    chk("rst_done", done === 1'b0);
    chk("rst_err", err === 1'b0);
    chk("rst_flag", ovf_flag === 1'b0);
    chk("rst_depth", depth === '0);
    step();
    step();
    reset = 1'b0;
    step();

    run(16'h4000, 16'h1234, 1'b0, 1'b0);
    run(16'h8000, 16'h0000, 1'b0, 1'b0);
    run(16'h1FE0, 16'h00AA, 1'b0, 1'b0);

    run(16'h4000, 16'h0005, 1'b0, 1'b0);
    run(16'h4000, 16'h0003, 1'b0, 1'b0);
    run(16'hC001, 16'h0000, 1'b0, 1'b0);

    run(16'hC013, 16'h0000, 1'b1, 1'b0);
    clear_flag();
    run(16'hC012, 16'h0000, 1'b1, 1'b1);
    clear_flag();

    run(16'h8000, 16'h0000, 1'b0, 1'b0);
    run(16'h8000, 16'h0000, 1'b0, 1'b0);
    run(16'hC014, 16'h0000, 1'b1, 1'b0);
    run(16'hC002, 16'h0000, 1'b0, 1'b0);
    if (CHKEN) mdepth = 0;

    for (int i = 0; i <= DEPTH; i++)
      run(16'h4000, 16'h0100 + 16'(i), 1'b0, 1'b0);

    instr       = 16'hC011;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("rs_settle_alu", aluOP === 4'h1);
    reset = 1'b1;
    #1;
    chk("rs_op", stackOP === OP_HOLD);
    chk("rs_alu", aluOP === 4'h0);
    chk("rs_ready", instr_ready === 1'b0);
    chk("rs_depth", depth === '0);
    chk("rs_imm", immediate === 16'h0000);
    step();
    reset    = 1'b0;
    mdepth   = 0;
    mflag    = 1'b0;
    last_alu = 4'h0;
    step();
    chk("rs_idle_ready", instr_ready === 1'b1);
    chk("rs_idle_done", done === 1'b0);
    chk("rs_idle_op", stackOP === OP_HOLD);

    run(16'h4000, 16'h0077, 1'b0, 1'b0);
    xfers = 0;
    dones = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (instr_ready) begin
        xfers++;
        instr     = (xfers == 1) ? 16'hC015 : 16'h4000;
        instr_imm = (xfers == 1) ? 16'h0000 : 16'hBEEF;
      end else begin
        instr     = 16'h8000;
        instr_imm = 16'h5555;
      end
      step();
      if (done) dones++;
    end
    instr_valid = 1'b0;
    mdepth++;
    chk("hold_xfers", xfers == 2);
    chk("hold_dones", dones == 2);
    chk("hold_imm", immediate === 16'hBEEF);
    chk("hold_alu", aluOP === 4'h5);
    chk("hold_depth", depth === exp_depth(mdepth));
    chk("hold_ready", instr_ready === 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
